// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: shared state encoding and default widths for the matrix-multiply core
package mat_mul_pkg;
    typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DIM_LOG_DEF = 1;
endpackage

// File: rtl/axis_out_fifo.sv
// axis_out_fifo: small synchronous circular-buffer FIFO with occupancy count
module axis_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 3,
    parameter int COUNT_W = $clog2(FIFO_DEPTH + 1)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [COUNT_W-1:0]    count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_P = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign rd_data = mem[rd_ptr];

    // storage, wrapping pointers and occupancy; storage cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
            count <= count + COUNT_W'(wr_en) - COUNT_W'(rd_en);
        end
    end
endmodule

// File: rtl/mat_out_streamer.sv
// mat_out_streamer: reads matR from BRAM in row-major order and streams it over AXI-Stream
module mat_out_streamer
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG = DIM_LOG_DEF,
    parameter int DIM = 2**DIM_LOG,
    parameter int SIZE = DIM*DIM,
    parameter int SIZE_LOG = 2*DIM_LOG,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 3
)(
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [SIZE_LOG-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [SIZE_LOG:0]   SIZE_C  = (SIZE_LOG+1)'(SIZE);
    localparam logic [SIZE_LOG-1:0] LAST_C  = SIZE_LOG'(SIZE - 1);
    localparam logic [CW:0]         DEPTH_C = (CW+1)'(FIFO_DEPTH);

    state_t state, state_nx;
    logic [SIZE_LOG:0]   issue_cnt;
    logic [SIZE_LOG-1:0] out_cnt;
    logic [CW-1:0]       fifo_cnt;
    logic                inflight, hs, last_hs;

    assign m00_axis_tstrb = '1;

    // state register
    always_ff @(posedge s00_axi_aclk)
        state <= !s00_axi_aresetn ? S_IDLE : state_nx;

    // next state: a start is only honoured while idle, so a start during a transfer is dropped
    always_comb
        state_nx = (state == S_IDLE) ? (start ? S_STREAM : S_IDLE)
                                     : (last_hs ? S_IDLE : S_STREAM);

    // outputs: read issue depends only on registered terms, never on tready
    always_comb begin
        busy            = state == S_STREAM;
        rd_en           = busy && (issue_cnt < SIZE_C)
                          && (({1'b0, fifo_cnt} + (CW+1)'(inflight)) < DEPTH_C);
        rd_addr         = issue_cnt[SIZE_LOG-1:0];
        m00_axis_tvalid = fifo_cnt != '0;
        m00_axis_tlast  = m00_axis_tvalid && (out_cnt == LAST_C);
        hs              = m00_axis_tvalid && m00_axis_tready;
        last_hs         = hs && (out_cnt == LAST_C);
    end

    // counters clear on reset and on the final handshake; inflight tracks the one-cycle BRAM latency
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn || last_hs) begin
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
        end else begin
            if (rd_en) issue_cnt <= issue_cnt + 1'b1;
            if (hs) out_cnt <= out_cnt + 1'b1;
            inflight <= rd_en;
        end
        done <= s00_axi_aresetn && last_hs;
    end

    axis_out_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .COUNT_W(CW)
    ) u_fifo (
        .clk(s00_axi_aclk),
        .rst_n(s00_axi_aresetn),
        .wr_en(inflight),
        .wr_data(rd_data),
        .rd_en(hs),
        .rd_data(m00_axis_tdata),
        .count(fifo_cnt)
    );
endmodule

// File: tb/tb_mat_out_streamer.sv
// tb_mat_out_streamer: scenario tasks checking the streamer against a queue-based reference
module tb_mat_out_streamer;
    localparam int DW = 32;

    logic clk = 1'b0, aresetn = 1'b0, start = 1'b0, start2 = 1'b0;
    always #5 clk = ~clk;

    logic busy, done, rd_en, tvalid, tlast, tready = 1'b0;
    logic [1:0] rd_addr;
    logic [DW-1:0] rd_data, tdata;
    logic [3:0] tstrb;
    logic [DW-1:0] mem1 [4];

    logic busy2, done2, rd_en2, tvalid2, tlast2, tready2 = 1'b0;
    logic [3:0] rd_addr2;
    logic [DW-1:0] rd_data2, tdata2;
    logic [3:0] tstrb2;
    logic [DW-1:0] mem2 [16];

    always @(posedge clk) if (rd_en) rd_data <= mem1[rd_addr];
    always @(posedge clk) if (rd_en2) rd_data2 <= mem2[rd_addr2];

    mat_out_streamer #(.DIM_LOG(1)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .m00_axis_tvalid(tvalid),
        .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb), .m00_axis_tlast(tlast), .m00_axis_tready(tready)
    );

    mat_out_streamer #(.DIM_LOG(2)) dut2 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .start(start2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .m00_axis_tvalid(tvalid2),
        .m00_axis_tdata(tdata2), .m00_axis_tstrb(tstrb2), .m00_axis_tlast(tlast2), .m00_axis_tready(tready2)
    );

    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] obs_d [$];
    logic obs_l [$];
    logic [DW-1:0] exp_q [$];
    int first_valid, first_hs, last_hs_c, done_c, iss20, n_done, n_stall, n_full, n_addr;
    logic [DW-1:0] held20;
    bit rd0;

    // mode: 0 ready always, 1 fixed toggle pattern, 2 random, 3 stalled for 20 cycles
    task automatic run1(input int mode, input int again, input bit restart, input int n_xfer, input int budget);
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        bit pv = 0, pr = 0, hsb;
        logic [DW-1:0] pd = '0;
        int issued = 0, popped = 0, tail = -1;
        obs_d.delete(); obs_l.delete();
        first_valid = -1; first_hs = -1; last_hs_c = -1; done_c = -1; iss20 = -1;
        n_done = 0; n_stall = 0; n_full = 0; n_addr = 0; held20 = '1; rd0 = 0;
        @(negedge clk); start = 1; tready = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c == 0) rd0 = rd_en && rd_addr == 2'd0;
            if (tvalid && first_valid < 0) first_valid = c;
            if (pv && !pr && (!tvalid || tdata !== pd)) n_stall++;
            if (rd_en) begin
                if (issued - popped >= 3) n_full++;
                if (int'(rd_addr) != issued % 4) n_addr++;
                issued++;
            end
            if (c == 19) begin iss20 = issued; held20 = tvalid ? tdata : '1; end
            if (done) begin n_done++; if (done_c < 0) done_c = c; end
            start = (c == again) || (restart && done && n_done == 1);
            tready = mode == 0 ? 1'b1 : mode == 1 ? pat[c % 7] : mode == 2 ? 1'($urandom_range(0, 1)) : (c >= 20);
            hsb = tvalid && tready;
            if (hsb) begin
                obs_d.push_back(tdata); obs_l.push_back(tlast); popped++;
                if (first_hs < 0) first_hs = c;
                last_hs_c = c;
            end
            pv = tvalid; pr = tready; pd = tdata;
            if (n_done == n_xfer && tail < 0) tail = c;
            if (tail >= 0 && c >= tail + 3) break;
        end
        start = 0; tready = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        aresetn = 0; start = 0; start2 = 0; tready = 0; tready2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_chk++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
        n_chk++; if (rd_addr !== 2'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_chk++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b expected 0", tvalid); end
        n_chk++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0b expected 0", tlast); end
        n_chk++; if (tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %0d expected 0", tdata); end
        n_chk++; if (tstrb !== 4'hf) begin n_fail++; $display("FAIL reset_tstrb: got %0h expected f", tstrb); end
        n_chk++; if (tvalid2 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2: got valid=%0b busy=%0b expected 0 0", tvalid2, busy2); end
        aresetn = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) mem1[i] = 32'(10 * (i + 1));
        run1(0, -1, 0, 1, 40);
        n_chk++; if (obs_d.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", obs_d.size()); end
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_chk++; if (obs_d[i] !== mem1[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, obs_d[i], mem1[i]); end
            n_chk++; if (obs_l[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_tlast[%0d]: got %0b expected %0b", i, obs_l[i], i == 3); end
        end
        n_chk++; if (!rd0) begin n_fail++; $display("FAIL basic_first_read: got 0 expected 1 (rd_en, addr 0 cycle after start)"); end
        n_chk++; if (first_valid != 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", first_valid); end
        n_chk++; if (last_hs_c - first_hs != 3) begin n_fail++; $display("FAIL basic_throughput: got span %0d expected 3", last_hs_c - first_hs); end
        n_chk++; if (done_c != last_hs_c + 1) begin n_fail++; $display("FAIL basic_done_timing: got %0d expected %0d", done_c, last_hs_c + 1); end
        n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0b expected 0", busy); end
    endtask

    task automatic test_backpressure(input int mode, input string nm);
        for (int i = 0; i < 4; i++) mem1[i] = $urandom;
        run1(mode, -1, 0, 1, 200);
        n_chk++; if (obs_d.size() != 4) begin n_fail++; $display("FAIL %s_count: got %0d expected 4", nm, obs_d.size()); end
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_chk++; if (obs_d[i] !== mem1[i]) begin n_fail++; $display("FAIL %s_data[%0d]: got %0h expected %0h", nm, i, obs_d[i], mem1[i]); end
            n_chk++; if (obs_l[i] !== (i == 3)) begin n_fail++; $display("FAIL %s_tlast[%0d]: got %0b expected %0b", nm, i, obs_l[i], i == 3); end
        end
        n_chk++; if (n_stall != 0) begin n_fail++; $display("FAIL %s_stall_stable: got %0d unstable cycles expected 0", nm, n_stall); end
        n_chk++; if (n_full != 0) begin n_fail++; $display("FAIL %s_full_read: got %0d reads while full expected 0", nm, n_full); end
        n_chk++; if (n_addr != 0) begin n_fail++; $display("FAIL %s_addr_order: got %0d bad addresses expected 0", nm, n_addr); end
        n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d expected 1", nm, n_done); end
    endtask

    task automatic test_long_stall();
        for (int i = 0; i < 4; i++) mem1[i] = $urandom;
        run1(3, -1, 0, 1, 100);
        n_chk++; if (iss20 != 3) begin n_fail++; $display("FAIL stall_reads: got %0d expected 3", iss20); end
        n_chk++; if (held20 !== mem1[0]) begin n_fail++; $display("FAIL stall_head: got %0h expected %0h", held20, mem1[0]); end
        n_chk++; if (n_stall != 0 || n_addr != 0) begin n_fail++; $display("FAIL stall_stable_addr: got %0d/%0d expected 0/0", n_stall, n_addr); end
        n_chk++; if (first_hs != 20 || last_hs_c != 23) begin n_fail++; $display("FAIL stall_release: got %0d..%0d expected 20..23", first_hs, last_hs_c); end
        n_chk++; if (obs_d.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", obs_d.size()); end
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_chk++; if (obs_d[i] !== mem1[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %0h expected %0h", i, obs_d[i], mem1[i]); end
        end
    endtask

    task automatic test_start_busy();
        for (int i = 0; i < 4; i++) mem1[i] = $urandom;
        exp_q.delete();
        for (int t = 0; t < 2; t++) for (int i = 0; i < 4; i++) exp_q.push_back(mem1[i]);
        run1(0, 3, 1, 2, 100);
        n_chk++; if (obs_d.size() != 8) begin n_fail++; $display("FAIL busy_count: got %0d expected 8", obs_d.size()); end
        for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
            n_chk++; if (obs_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_data[%0d]: got %0h expected %0h", i, obs_d[i], exp_q[i]); end
            n_chk++; if (obs_l[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL busy_tlast[%0d]: got %0b expected %0b", i, obs_l[i], i % 4 == 3); end
        end
        n_chk++; if (n_done != 2) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 2", n_done); end
        n_chk++; if (done_c != 6) begin n_fail++; $display("FAIL busy_first_done: got %0d expected 6", done_c); end
        n_chk++; if (n_addr != 0) begin n_fail++; $display("FAIL busy_addr_order: got %0d expected 0", n_addr); end
    endtask

    task automatic test_reset_mid();
        int nhs = 0, bad = 0;
        for (int i = 0; i < 4; i++) mem1[i] = 32'(10 * (i + 1));
        @(negedge clk); start = 1; tready = 1;
        for (int c = 0; c < 30 && nhs < 2; c++) begin
            @(negedge clk); start = 0;
            if (tvalid) nhs++;
        end
        @(negedge clk); aresetn = 0; tready = 0;
        @(negedge clk);
        n_chk++; if (nhs != 2) begin n_fail++; $display("FAIL rstmid_handshakes: got %0d expected 2", nhs); end
        n_chk++; if ({busy, done, rd_en, tvalid, tlast} !== 5'b0) begin n_fail++; $display("FAIL rstmid_outputs: got %05b expected 00000", {busy, done, rd_en, tvalid, tlast}); end
        n_chk++; if (rd_addr !== 2'd0 || tdata !== '0) begin n_fail++; $display("FAIL rstmid_addr_data: got %0d/%0d expected 0/0", rd_addr, tdata); end
        aresetn = 1; tready = 1;
        repeat (6) begin
            @(negedge clk);
            if (tvalid || tlast || done || busy || rd_en) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
        tready = 0;
        run1(0, -1, 0, 1, 40);
        n_chk++; if (!rd0) begin n_fail++; $display("FAIL rstmid_restart_addr0: got 0 expected 1"); end
        n_chk++; if (obs_d.size() != 4) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 4", obs_d.size()); end
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_chk++; if (obs_d[i] !== mem1[i]) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %0d expected %0d", i, obs_d[i], mem1[i]); end
        end
    endtask

    task automatic test_dim4();
        int issued = 0, bad_addr = 0, maxa = 0, nd = 0, tail = -1;
        for (int i = 0; i < 16; i++) mem2[i] = 32'(i * 3);
        obs_d.delete(); obs_l.delete();
        @(negedge clk); start2 = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); start2 = 0;
            if (rd_en2) begin
                if (int'(rd_addr2) != issued) bad_addr++;
                if (int'(rd_addr2) > maxa) maxa = int'(rd_addr2);
                issued++;
            end
            if (done2) nd++;
            tready2 = 1'($urandom_range(0, 1));
            if (tvalid2 && tready2) begin obs_d.push_back(tdata2); obs_l.push_back(tlast2); end
            if (nd > 0 && tail < 0) tail = c;
            if (tail >= 0 && c >= tail + 3) break;
        end
        tready2 = 0;
        n_chk++; if (obs_d.size() != 16) begin n_fail++; $display("FAIL dim4_count: got %0d expected 16", obs_d.size()); end
        for (int i = 0; i < 16 && i < obs_d.size(); i++) begin
            n_chk++; if (obs_d[i] !== 32'(i * 3)) begin n_fail++; $display("FAIL dim4_data[%0d]: got %0d expected %0d", i, obs_d[i], i * 3); end
            n_chk++; if (obs_l[i] !== (i == 15)) begin n_fail++; $display("FAIL dim4_tlast[%0d]: got %0b expected %0b", i, obs_l[i], i == 15); end
        end
        n_chk++; if (bad_addr != 0 || issued != 16) begin n_fail++; $display("FAIL dim4_addr: got %0d bad, %0d reads expected 0, 16", bad_addr, issued); end
        n_chk++; if (maxa != 15) begin n_fail++; $display("FAIL dim4_addr_max: got %0d expected 15", maxa); end
        n_chk++; if (nd != 1) begin n_fail++; $display("FAIL dim4_done_count: got %0d expected 1", nd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure(1, "bp");
        repeat (3) test_backpressure(2, "rand");
        test_long_stall();
        test_start_busy();
        test_reset_mid();
        test_dim4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
